// File: rtl/ttl74x190.sv
// SN74LS190-style synchronous BCD up/down decade counter with async master reset.
// Optional build macro TTL74X190_INVALID_RECOVER_EN: counts from states 10-15 jump straight back into 0..9.
module ttl74x190 (
   input  logic       clk,
   input  logic       MR,
   input  logic       LOAD_n,
   input  logic       CTEN_n,
   input  logic       D_U,
   input  logic [3:0] P,
   output logic [3:0] Q,
   output logic       MAX_MIN,
   output logic       RCO_n
);

   localparam int              WIDTH     = 4;
   localparam logic [WIDTH-1:0] MAX_COUNT = 4'd9;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] count_s;
   logic [WIDTH-1:0] next_s;
   logic             max_min_s;

   // Next value when counting, in the direction sampled this cycle
   always_comb begin
      count_s = q_r;
      if (D_U == 1'b0) begin
`ifdef TTL74X190_INVALID_RECOVER_EN
         if (q_r > MAX_COUNT) begin
            count_s = 4'd0;
         end else if (q_r == MAX_COUNT) begin
            count_s = 4'd0;
         end else begin
            count_s = q_r + 4'd1;
         end
`else
         // 15 wraps to 0 through the natural 4-bit overflow
         if (q_r == MAX_COUNT) begin
            count_s = 4'd0;
         end else begin
            count_s = q_r + 4'd1;
         end
`endif
      end else begin
`ifdef TTL74X190_INVALID_RECOVER_EN
         if (q_r > MAX_COUNT) begin
            count_s = MAX_COUNT;
         end else if (q_r == 4'd0) begin
            count_s = MAX_COUNT;
         end else begin
            count_s = q_r - 4'd1;
         end
`else
         if (q_r == 4'd0) begin
            count_s = MAX_COUNT;
         end else begin
            count_s = q_r - 4'd1;
         end
`endif
      end
   end

   // Load has priority over count; otherwise hold
   always_comb begin
      next_s = q_r;
      case ({LOAD_n, CTEN_n})
         2'b00:   next_s = P;
         2'b01:   next_s = P;
         2'b10:   next_s = count_s;
         2'b11:   next_s = q_r;
         default: next_s = q_r;
      endcase
   end

   // Count register with asynchronous master reset
   always_ff @(posedge clk or posedge MR) begin
      if (MR) begin
         q_r <= 4'd0;
      end else begin
         q_r <= next_s;
      end
   end

   // Terminal flag follows direction immediately; ripple output only in the clk-low phase
   always_comb begin
      max_min_s = 1'b0;
      if (D_U == 1'b0) begin
         max_min_s = (q_r == MAX_COUNT);
      end else begin
         max_min_s = (q_r == 4'd0);
      end
   end

   assign Q       = q_r;
   assign MAX_MIN = max_min_s;
   assign RCO_n   = ~(max_min_s & ~CTEN_n & ~clk);

endmodule

// File: tb/tb_ttl74x190.sv
// Self-checking bench for ttl74x190: directed scenarios plus randomized traffic against a decade-counter model.
module tb_ttl74x190;

   logic       clk = 1'b0;
   logic       MR = 1'b1;
   logic       LOAD_n = 1'b1;
   logic       CTEN_n = 1'b1;
   logic       D_U = 1'b0;
   logic [3:0] P = 4'd0;
   logic [3:0] Q;
   logic       MAX_MIN;
   logic       RCO_n;

   int errors = 0;
   int checks = 0;
   int mq = 0;

   ttl74x190 dut (
      .clk(clk), .MR(MR), .LOAD_n(LOAD_n), .CTEN_n(CTEN_n), .D_U(D_U),
      .P(P), .Q(Q), .MAX_MIN(MAX_MIN), .RCO_n(RCO_n)
   );

   always #5 clk = ~clk;

   // Reference next-count: decade sequence on 0..9, build-dependent handling of 10..15
   function automatic int ref_count(int q, bit down);
      if (!down) begin
`ifdef TTL74X190_INVALID_RECOVER_EN
         if (q > 9) return 0;
`endif
         if (q == 9) return 0;
         return (q + 1) % 16;
      end else begin
`ifdef TTL74X190_INVALID_RECOVER_EN
         if (q > 9) return 9;
`endif
         if (q == 0) return 9;
         return q - 1;
      end
   endfunction

   function automatic bit ref_term(int q, bit down);
      return down ? (q == 0) : (q == 9);
   endfunction

   // One rising edge: advance the model with the inputs present at the edge, settle 1ns
   task automatic tick();
      @(posedge clk);
      if (MR) mq = 0;
      else if (!LOAD_n) mq = int'(P);
      else if (!CTEN_n) mq = ref_count(mq, D_U);
      #1;
   endtask

   task automatic load(input int v);
      LOAD_n = 1'b0; P = v[3:0];
      tick();
      LOAD_n = 1'b1;
   endtask

   task automatic test_reset();
      MR = 1'b1;
      tick();
      checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_init Q=%0d exp=0", Q); end
      MR = 1'b0;
      load(5);
      CTEN_n = 1'b0; D_U = 1'b0;
      tick();
      checks++; if (Q !== 4'd6) begin errors++; $display("FAIL reset_precount Q=%0d exp=6", Q); end
      #2; MR = 1'b1; D_U = 1'b1; mq = 0;
      #1;
      checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_async Q=%0d exp=0", Q); end
      checks++; if (MAX_MIN !== 1'b1) begin errors++; $display("FAIL reset_maxmin MAX_MIN=%0b exp=1", MAX_MIN); end
      @(negedge clk); #1;
      checks++; if (RCO_n !== 1'b0) begin errors++; $display("FAIL reset_rco RCO_n=%0b exp=0", RCO_n); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_hold edge%0d Q=%0d exp=0", i, Q); end
      end
      MR = 1'b0; CTEN_n = 1'b1;
   endtask

   task automatic test_down_count();
      int exp_seq [5] = '{2, 1, 0, 9, 8};
      load(3);
      D_U = 1'b1; CTEN_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (Q !== exp_seq[i][3:0]) begin errors++; $display("FAIL down_q step%0d Q=%0d exp=%0d", i, Q, exp_seq[i]); end
         checks++; if (MAX_MIN !== (exp_seq[i] == 0)) begin errors++; $display("FAIL down_maxmin step%0d MAX_MIN=%0b exp=%0b", i, MAX_MIN, exp_seq[i] == 0); end
         checks++; if (RCO_n !== 1'b1) begin errors++; $display("FAIL down_rco_high step%0d RCO_n=%0b exp=1", i, RCO_n); end
         @(negedge clk); #1;
         checks++; if (RCO_n !== (exp_seq[i] != 0)) begin errors++; $display("FAIL down_rco_low step%0d RCO_n=%0b exp=%0b", i, RCO_n, exp_seq[i] != 0); end
      end
      CTEN_n = 1'b1;
   endtask

   task automatic test_up_wrap();
      int exp_seq [4] = '{8, 9, 0, 1};
      load(7);
      D_U = 1'b0; CTEN_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (Q !== exp_seq[i][3:0]) begin errors++; $display("FAIL up_q step%0d Q=%0d exp=%0d", i, Q, exp_seq[i]); end
         checks++; if (MAX_MIN !== (exp_seq[i] == 9)) begin errors++; $display("FAIL up_maxmin step%0d MAX_MIN=%0b exp=%0b", i, MAX_MIN, exp_seq[i] == 9); end
      end
      CTEN_n = 1'b1;
      load(9);
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (Q !== 4'd9) begin errors++; $display("FAIL up_hold Q=%0d exp=9", Q); end
         checks++; if (MAX_MIN !== 1'b1) begin errors++; $display("FAIL up_hold_maxmin MAX_MIN=%0b exp=1", MAX_MIN); end
         @(negedge clk); #1;
         checks++; if (RCO_n !== 1'b1) begin errors++; $display("FAIL up_hold_rco RCO_n=%0b exp=1", RCO_n); end
      end
   endtask

   task automatic test_priority();
      LOAD_n = 1'b0; P = 4'd4; CTEN_n = 1'b0; D_U = 1'b1;
      tick();
      LOAD_n = 1'b1; CTEN_n = 1'b1;
      checks++; if (Q !== 4'd4) begin errors++; $display("FAIL prio_load Q=%0d exp=4", Q); end
      D_U = 1'b0;
      load(5);
      D_U = 1'b1; CTEN_n = 1'b0;
      tick();
      CTEN_n = 1'b1;
      checks++; if (Q !== 4'd4) begin errors++; $display("FAIL prio_dir Q=%0d exp=4", Q); end
      D_U = 1'b0;
      load(0);
      checks++; if (MAX_MIN !== 1'b0) begin errors++; $display("FAIL dir_mm_up MAX_MIN=%0b exp=0", MAX_MIN); end
      D_U = 1'b1; #1;
      checks++; if (MAX_MIN !== 1'b1) begin errors++; $display("FAIL dir_mm_down MAX_MIN=%0b exp=1", MAX_MIN); end
   endtask

   task automatic test_invalid();
      int ld [3];
      int dir [3];
      int exp_q [3];
`ifdef TTL74X190_INVALID_RECOVER_EN
      ld = '{12, 13, 15}; dir = '{1, 0, 1}; exp_q = '{9, 0, 9};
`else
      ld = '{15, 10, 11}; dir = '{0, 1, 0}; exp_q = '{0, 9, 12};
`endif
      for (int i = 0; i < 3; i++) begin
         CTEN_n = 1'b1; D_U = dir[i][0];
         load(ld[i]);
         checks++; if (MAX_MIN !== 1'b0) begin errors++; $display("FAIL inv_maxmin ld=%0d MAX_MIN=%0b exp=0", ld[i], MAX_MIN); end
         CTEN_n = 1'b0;
         tick();
         checks++; if (Q !== exp_q[i][3:0]) begin errors++; $display("FAIL inv_count ld=%0d Q=%0d exp=%0d", ld[i], Q, exp_q[i]); end
      end
      CTEN_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         MR     = ($urandom_range(0, 49) == 0);
         LOAD_n = ($urandom_range(0, 99) >= 15);
         CTEN_n = ($urandom_range(0, 3) == 0);
         D_U    = $urandom_range(0, 1);
         P      = 4'($urandom_range(0, 15));
         #1;
         if (MR) begin
            mq = 0;
            checks++; if (Q !== 4'd0) begin errors++; $display("FAIL rnd_async it%0d Q=%0d exp=0", i, Q); end
         end
         tick();
         checks++; if (Q !== mq[3:0]) begin errors++; $display("FAIL rnd_q it%0d Q=%0d exp=%0d", i, Q, mq); end
         checks++; if (MAX_MIN !== ref_term(mq, D_U)) begin errors++; $display("FAIL rnd_maxmin it%0d MAX_MIN=%0b exp=%0b", i, MAX_MIN, ref_term(mq, D_U)); end
         @(negedge clk); #1;
         checks++; if (RCO_n !== !(ref_term(mq, D_U) && !CTEN_n)) begin errors++; $display("FAIL rnd_rco it%0d RCO_n=%0b exp=%0b", i, RCO_n, !(ref_term(mq, D_U) && !CTEN_n)); end
      end
      MR = 1'b0;
   endtask

   initial begin
      test_reset();
      test_down_count();
      test_up_wrap();
      test_priority();
      test_invalid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
